// File: rtl/l2_port_merger_pkg.sv
// l2_config_and_types: shared L2 port-merger widths, FSM states and request struct.
package l2_config_and_types;
  localparam int L2_NUM_PORTS = 4;
  localparam int L2_SUB_ID_W = 4;
  localparam int L2_BURST_W = 5;
  localparam int L2_ADDR_W = 30;
  localparam int L2_DATA_W = 32;
  localparam int L2_ID_W = $clog2(L2_NUM_PORTS) + L2_SUB_ID_W;
  typedef enum logic {ARB, WDATA} merger_state_e;
  typedef struct packed {
    logic [L2_ADDR_W-1:0] addr;
    logic [L2_DATA_W/8-1:0] be;
    logic rnw;
    logic is_amo;
    logic [L2_BURST_W-1:0] burst;
    logic [L2_ID_W-1:0] id;
  } l2_req_t;
  function automatic int port_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/l2_rr_arbiter.sv
// l2_rr_arbiter: round-robin grant over a request vector, pointer advances past each taken grant.
module l2_rr_arbiter
  import l2_config_and_types::*;
#(
  parameter int NUM_PORTS = L2_NUM_PORTS,
  localparam int PORT_W = port_w(NUM_PORTS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_PORTS-1:0] i_req,
  input  logic                 i_take,
  output logic [NUM_PORTS-1:0] o_grant,
  output logic [PORT_W-1:0]    o_idx,
  output logic                 o_any
);
  logic [PORT_W-1:0] r_ptr;
  logic [PORT_W-1:0] w_j;
  // scanning from farthest to nearest lets the pointer's own port win last
  always_comb begin
    o_idx = '0;
    o_any = 1'b0;
    w_j = '0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      w_j = PORT_W'((int'(r_ptr) + k) % NUM_PORTS);
      if (i_req[w_j]) begin
        o_idx = w_j;
        o_any = 1'b1;
      end
    end
  end
  assign o_grant = o_any ? NUM_PORTS'(1) << o_idx : '0;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_ptr <= '0;
    else if (i_take && o_any) r_ptr <= (int'(o_idx) == NUM_PORTS - 1) ? '0 : o_idx + 1'b1;
endmodule

// File: rtl/l2_port_merger.sv
// l2_port_merger: N-to-1 L2 request merger with burst-locked write data and id-routed read responses.
module l2_port_merger
  import l2_config_and_types::*;
#(
  parameter int NUM_PORTS = L2_NUM_PORTS,
  parameter int SUB_ID_W = L2_SUB_ID_W,
  parameter int ADDR_W = 30,
  parameter int DATA_W = 32,
  parameter int BURST_W = L2_BURST_W,
  localparam int PORT_W = port_w(NUM_PORTS),
  localparam int ID_W = PORT_W + SUB_ID_W
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_PORTS-1:0]                 req_valid,
  output logic [NUM_PORTS-1:0]                 req_ready,
  input  logic [NUM_PORTS-1:0][ADDR_W-1:0]     req_addr,
  input  logic [NUM_PORTS-1:0][DATA_W/8-1:0]   req_be,
  input  logic [NUM_PORTS-1:0]                 req_rnw,
  input  logic [NUM_PORTS-1:0]                 req_is_amo,
  input  logic [NUM_PORTS-1:0][BURST_W-1:0]    req_burst,
  input  logic [NUM_PORTS-1:0][SUB_ID_W-1:0]   req_sub_id,
  input  logic [NUM_PORTS-1:0][DATA_W-1:0]     wr_data,
  input  logic [NUM_PORTS-1:0]                 wr_valid,
  output logic [NUM_PORTS-1:0]                 wr_ready,
  output logic [DATA_W-1:0]                    rd_data,
  output logic [SUB_ID_W-1:0]                  rd_sub_id,
  output logic [NUM_PORTS-1:0]                 rd_valid,
  output logic [ADDR_W-1:0]                    mem_addr,
  output logic [DATA_W/8-1:0]                  mem_be,
  output logic                                 mem_rnw,
  output logic                                 mem_is_amo,
  output logic [BURST_W-1:0]                   mem_burst,
  output logic [ID_W-1:0]                      mem_id,
  output logic                                 mem_request_valid,
  input  logic                                 mem_request_pop,
  output logic [DATA_W-1:0]                    mem_wr_data,
  output logic                                 mem_wr_data_valid,
  input  logic                                 mem_wr_data_read,
  input  logic [DATA_W-1:0]                    mem_rd_data,
  input  logic [ID_W-1:0]                      mem_rd_id,
  input  logic                                 mem_rd_data_valid,
  output logic                                 bad_id
);
  merger_state_e r_state;
  logic [PORT_W-1:0] r_lock;
  logic [BURST_W:0] r_beats;
  logic [NUM_PORTS-1:0] w_grant;
  logic [PORT_W-1:0] w_g, w_p;
  logic w_any, w_load, w_wxfer, w_p_ok;
  l2_rr_arbiter #(.NUM_PORTS(NUM_PORTS)) u_arb (
    .clk(clk), .rst(rst), .i_req(req_valid), .i_take(w_load),
    .o_grant(w_grant), .o_idx(w_g), .o_any(w_any)
  );
  assign w_load = (r_state == ARB) && (!mem_request_valid || mem_request_pop) && w_any;
  assign req_ready = w_load ? w_grant : '0;
  assign mem_wr_data = wr_data[r_lock];
  assign mem_wr_data_valid = (r_state == WDATA) && wr_valid[r_lock];
  assign wr_ready = (r_state == WDATA && mem_wr_data_read) ? NUM_PORTS'(1) << r_lock : '0;
  assign w_wxfer = mem_wr_data_valid && mem_wr_data_read;
  assign w_p = mem_rd_id[ID_W-1:SUB_ID_W];
  assign w_p_ok = int'(w_p) < NUM_PORTS;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state <= ARB;
      r_lock <= '0;
      r_beats <= '0;
      mem_request_valid <= 1'b0;
      mem_addr <= '0;
      mem_be <= '0;
      mem_rnw <= 1'b0;
      mem_is_amo <= 1'b0;
      mem_burst <= '0;
      mem_id <= '0;
    end else begin
      if (w_load) begin
        mem_request_valid <= 1'b1;
        mem_addr <= req_addr[w_g];
        mem_be <= req_be[w_g];
        mem_rnw <= req_rnw[w_g];
        mem_is_amo <= req_is_amo[w_g];
        mem_burst <= req_burst[w_g];
        mem_id <= {w_g, req_sub_id[w_g]};
        if (!req_rnw[w_g]) begin
          r_state <= WDATA;
          r_lock <= w_g;
          r_beats <= req_is_amo[w_g] ? (BURST_W+1)'(1) : {1'b0, req_burst[w_g]} + (BURST_W+1)'(1);
        end
      end else if (mem_request_pop) mem_request_valid <= 1'b0;
      if (w_wxfer) begin
        r_beats <= r_beats - 1'b1;
        if (r_beats == (BURST_W+1)'(1)) r_state <= ARB;
      end
    end
  // responses naming a port beyond NUM_PORTS are dropped and flagged
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rd_valid <= '0;
      rd_data <= '0;
      rd_sub_id <= '0;
      bad_id <= 1'b0;
    end else begin
      rd_valid <= (mem_rd_data_valid && w_p_ok) ? NUM_PORTS'(1) << w_p : '0;
      if (mem_rd_data_valid && w_p_ok) begin
        rd_data <= mem_rd_data;
        rd_sub_id <= mem_rd_id[SUB_ID_W-1:0];
      end
      if (mem_rd_data_valid && !w_p_ok) bad_id <= 1'b1;
    end
endmodule

// File: tb/tb_l2_port_merger.sv
// tb_l2_port_merger: directed self-checking bench for l2_port_merger (4-port and 3-port builds).
module tb_l2_port_merger;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] req_valid, req_ready, req_rnw, req_is_amo, wr_valid, wr_ready, rd_valid;
  logic [3:0][29:0] req_addr;
  logic [3:0][3:0] req_be, req_sub_id;
  logic [3:0][4:0] req_burst;
  logic [3:0][31:0] wr_data;
  logic [31:0] rd_data, mem_wr_data, mem_rd_data;
  logic [3:0] rd_sub_id, mem_be;
  logic [29:0] mem_addr;
  logic mem_rnw, mem_is_amo, mem_request_valid, mem_request_pop;
  logic [4:0] mem_burst;
  logic [5:0] mem_id, mem_rd_id;
  logic mem_wr_data_valid, mem_wr_data_read, mem_rd_data_valid, bad_id;
  logic [2:0] u3_req_ready, u3_wr_ready, u3_rd_valid;
  logic [31:0] u3_rd_data, u3_mem_wr_data;
  logic [3:0] u3_rd_sub_id, u3_mem_be;
  logic [29:0] u3_mem_addr;
  logic u3_mem_rnw, u3_mem_is_amo, u3_mem_request_valid, u3_mem_wr_data_valid, u3_bad_id;
  logic [4:0] u3_mem_burst;
  logic [5:0] u3_mem_id, u3_rd_id;
  logic u3_rd_v;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  l2_port_merger #(.NUM_PORTS(4), .SUB_ID_W(4), .ADDR_W(30), .DATA_W(32), .BURST_W(5)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_be(req_be), .req_rnw(req_rnw), .req_is_amo(req_is_amo), .req_burst(req_burst),
    .req_sub_id(req_sub_id), .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_sub_id(rd_sub_id), .rd_valid(rd_valid), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_rnw(mem_rnw), .mem_is_amo(mem_is_amo), .mem_burst(mem_burst),
    .mem_id(mem_id), .mem_request_valid(mem_request_valid), .mem_request_pop(mem_request_pop),
    .mem_wr_data(mem_wr_data), .mem_wr_data_valid(mem_wr_data_valid),
    .mem_wr_data_read(mem_wr_data_read), .mem_rd_data(mem_rd_data), .mem_rd_id(mem_rd_id),
    .mem_rd_data_valid(mem_rd_data_valid), .bad_id(bad_id)
  );

  l2_port_merger #(.NUM_PORTS(3), .SUB_ID_W(4), .ADDR_W(30), .DATA_W(32), .BURST_W(5)) u3 (
    .clk(clk), .rst(rst), .req_valid(3'b0), .req_ready(u3_req_ready), .req_addr('0),
    .req_be('0), .req_rnw(3'b111), .req_is_amo(3'b0), .req_burst('0),
    .req_sub_id('0), .wr_data('0), .wr_valid(3'b0), .wr_ready(u3_wr_ready),
    .rd_data(u3_rd_data), .rd_sub_id(u3_rd_sub_id), .rd_valid(u3_rd_valid), .mem_addr(u3_mem_addr),
    .mem_be(u3_mem_be), .mem_rnw(u3_mem_rnw), .mem_is_amo(u3_mem_is_amo), .mem_burst(u3_mem_burst),
    .mem_id(u3_mem_id), .mem_request_valid(u3_mem_request_valid), .mem_request_pop(1'b1),
    .mem_wr_data(u3_mem_wr_data), .mem_wr_data_valid(u3_mem_wr_data_valid),
    .mem_wr_data_read(1'b0), .mem_rd_data(mem_rd_data), .mem_rd_id(u3_rd_id),
    .mem_rd_data_valid(u3_rd_v), .bad_id(u3_bad_id)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    req_valid = '0; req_rnw = '1; req_is_amo = '0; req_burst = '0; wr_valid = '0;
    mem_request_pop = 1'b0; mem_wr_data_read = 1'b0; mem_rd_data = '0; mem_rd_id = '0;
    mem_rd_data_valid = 1'b0; u3_rd_v = 1'b0; u3_rd_id = '0;
    for (int i = 0; i < 4; i++) begin
      req_addr[i] = 30'h100 + 30'(i);
      req_be[i] = 4'hF;
      req_sub_id[i] = 4'(8 + i);
      wr_data[i] = 32'hA0 + 32'(i);
    end
    @(negedge clk); @(negedge clk);
    chk("rst_mem_valid", 64'(mem_request_valid), 0);
    chk("rst_mem_id", 64'(mem_id), 0);
    chk("rst_mem_addr", 64'(mem_addr), 0);
    chk("rst_rd_valid", 64'(rd_valid), 0);
    chk("rst_bad_id", 64'(bad_id), 0);
    chk("rst_u3_bad_id", 64'(u3_bad_id), 0);
    rst = 1'b0;
    // all four ports reading, pop every cycle
    req_valid = 4'hF; mem_request_pop = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk("rr_ready", 64'(req_ready), 64'(1) << (k % 4));
      if (k > 0) begin
        chk("rr_mem_valid", 64'(mem_request_valid), 1);
        chk("rr_mem_id", 64'(mem_id), 64'({2'((k - 1) % 4), 4'(8 + (k - 1) % 4)}));
        chk("rr_mem_addr", 64'(mem_addr), 64'(30'h100 + 30'((k - 1) % 4)));
      end
      @(negedge clk);
    end
    // port 2 burst write of 4 beats with port 1 read waiting
    req_rnw[2] = 1'b0; req_burst[2] = 5'd3; req_valid = 4'b0110; wr_valid = 4'b0110;
    wr_data[1] = 32'h1111_1111; wr_data[2] = 32'hD000_0000; mem_wr_data_read = 1'b0;
    #1 chk("wr_grant", 64'(req_ready), 64'b0100);
    @(negedge clk);
    req_valid = 4'b0010;
    #1;
    chk("wr_mem_id", 64'(mem_id), 64'({2'd2, 4'hA}));
    chk("wr_mem_rnw", 64'(mem_rnw), 0);
    chk("wr_mem_burst", 64'(mem_burst), 3);
    chk("wr_dvalid", 64'(mem_wr_data_valid), 1);
    chk("wr_ready_idle", 64'(wr_ready), 0);
    mem_wr_data_read = 1'b1;
    for (int b = 0; b < 4; b++) begin
      wr_data[2] = 32'hD000_0000 + 32'(b);
      #1;
      chk("beat_wr_ready", 64'(wr_ready), 64'b0100);
      chk("beat_data", 64'(mem_wr_data), 64'(32'hD000_0000 + 32'(b)));
      chk("beat_no_grant", 64'(req_ready), 0);
      @(negedge clk);
    end
    #1;
    chk("grant_after_burst", 64'(req_ready), 64'b0010);
    chk("arb_dvalid", 64'(mem_wr_data_valid), 0);
    chk("arb_wr_ready", 64'(wr_ready), 0);
    @(negedge clk);
    req_valid = '0; mem_wr_data_read = 1'b0;
    #1;
    chk("p1_mem_id", 64'(mem_id), 64'({2'd1, 4'h9}));
    chk("p1_mem_rnw", 64'(mem_rnw), 1);
    // AMO on port 0: one beat regardless of burst field
    req_rnw[0] = 1'b0; req_is_amo[0] = 1'b1; req_burst[0] = 5'h0B; req_valid = 4'b0001;
    wr_valid = 4'b0001; wr_data[0] = 32'hA5A5_0001;
    @(negedge clk);
    req_valid = '0;
    #1;
    chk("amo_is_amo", 64'(mem_is_amo), 1);
    chk("amo_burst", 64'(mem_burst), 64'h0B);
    chk("amo_mem_id", 64'(mem_id), 64'({2'd0, 4'h8}));
    chk("amo_dvalid", 64'(mem_wr_data_valid), 1);
    mem_wr_data_read = 1'b1;
    #1;
    chk("amo_wr_ready", 64'(wr_ready), 64'b0001);
    chk("amo_data", 64'(mem_wr_data), 64'hA5A5_0001);
    @(negedge clk);
    req_rnw[0] = 1'b1; req_is_amo[0] = 1'b0; req_valid = 4'b0001;
    #1;
    chk("amo_done_ready", 64'(wr_ready), 0);
    chk("amo_done_dvalid", 64'(mem_wr_data_valid), 0);
    chk("amo_back_arb", 64'(req_ready), 64'b0001);
    @(negedge clk);
    req_valid = '0; mem_wr_data_read = 1'b0;
    // read responses back-to-back
    mem_rd_id = {2'd3, 4'd2}; mem_rd_data = 32'hDEADBEEF; mem_rd_data_valid = 1'b1;
    @(negedge clk);
    mem_rd_id = {2'd1, 4'd5}; mem_rd_data = 32'h1234_5678;
    #1;
    chk("rsp0_valid", 64'(rd_valid), 64'b1000);
    chk("rsp0_data", 64'(rd_data), 64'hDEADBEEF);
    chk("rsp0_sub", 64'(rd_sub_id), 2);
    @(negedge clk);
    mem_rd_data_valid = 1'b0;
    #1;
    chk("rsp1_valid", 64'(rd_valid), 64'b0010);
    chk("rsp1_data", 64'(rd_data), 64'h1234_5678);
    chk("rsp1_sub", 64'(rd_sub_id), 5);
    @(negedge clk);
    chk("rsp_pulse_end", 64'(rd_valid), 0);
    chk("rsp_hold", 64'(rd_data), 64'h1234_5678);
    chk("rsp_bad_id4", 64'(bad_id), 0);
    // 3-port build: port field 3 is nonexistent
    u3_rd_id = {2'd3, 4'd1}; u3_rd_v = 1'b1; mem_rd_data = 32'hBAD0_0003;
    @(negedge clk);
    u3_rd_id = {2'd2, 4'd7}; mem_rd_data = 32'hCAFE_0002;
    #1;
    chk("bad_rd_valid", 64'(u3_rd_valid), 0);
    chk("bad_rd_data", 64'(u3_rd_data), 0);
    chk("bad_id_set", 64'(u3_bad_id), 1);
    @(negedge clk);
    u3_rd_v = 1'b0;
    #1;
    chk("u3_rd_valid", 64'(u3_rd_valid), 64'b100);
    chk("u3_rd_data", 64'(u3_rd_data), 64'hCAFE_0002);
    chk("u3_rd_sub", 64'(u3_rd_sub_id), 7);
    @(negedge clk);
    chk("bad_id_sticky", 64'(u3_bad_id), 1);
    // reset during beat 2 of a 4-beat burst from port 1
    mem_request_pop = 1'b0; req_rnw[1] = 1'b0; req_burst[1] = 5'd3;
    req_valid = 4'b0010; wr_valid = 4'b0010;
    #1 chk("rstb_grant", 64'(req_ready), 64'b0010);
    @(negedge clk);
    req_valid = '0; mem_wr_data_read = 1'b1;
    #1 chk("rstb_beat1", 64'(wr_ready), 64'b0010);
    @(negedge clk);
    #1 chk("rstb_beat2", 64'(wr_ready), 64'b0010);
    rst = 1'b1;
    #1;
    chk("rstb_wr_ready", 64'(wr_ready), 0);
    chk("rstb_mem_valid", 64'(mem_request_valid), 0);
    chk("rstb_mem_id", 64'(mem_id), 0);
    chk("rstb_mem_addr", 64'(mem_addr), 0);
    chk("rstb_dvalid", 64'(mem_wr_data_valid), 0);
    chk("rstb_rd_data", 64'(rd_data), 0);
    chk("rstb_u3_bad_id", 64'(u3_bad_id), 0);
    @(negedge clk);
    rst = 1'b0; req_rnw = '1; req_burst = '0; req_valid = 4'hF;
    #1;
    chk("post_rst_grant", 64'(req_ready), 64'b0001);
    chk("post_rst_wr_ready", 64'(wr_ready), 0);
    @(negedge clk);
    req_valid = '0;
    #1 chk("post_rst_mem_id", 64'(mem_id), 64'({2'd0, 4'h8}));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
